// File: rtl/stage_id_hs.sv
// Decode stage with valid/ready slot, register file and load-use stall.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, instr, pc, pc4, flush;
// wb_en/wb_idx/wb_data write-back; out_valid/out_ready; decoded controls
// (alu_op, br_op, funct3, op1_ctrl, op2_ctrl, rd_src, mem_rd, mem_wr,
// illegal), indices, imm, operand data, pc_o, pc4_o; stall_cnt.
// Optional macro ID_WB_BYPASS_EN: operands capture same-cycle wb_data.
module stage_id_hs #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  pc4,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_idx,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [1:0]       br_op,
  output logic [2:0]       funct3,
  output logic             op1_ctrl,
  output logic             op2_ctrl,
  output logic             rd_src,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             illegal,
  output logic [4:0]       rs1_idx,
  output logic [4:0]       rs2_idx,
  output logic [4:0]       rd_idx,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc4_o,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int IW = $clog2(NREG);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_NOP = 4'b1111;
  localparam logic [1:0] BR_NO   = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_UNC  = 2'd2;

  typedef struct packed {
    logic            v;
    logic [3:0]      alu;
    logic [1:0]      br;
    logic [2:0]      f3;
    logic            op1;
    logic            op2;
    logic            rds;
    logic            mrd;
    logic            mwr;
    logic            ill;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } slot_t;

  slot_t            slot_q, slot_d, dec_s, nop_s;
  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0]  opc;
  logic        is_r, is_i, is_ld, is_st, is_br;
  logic        is_jal, is_jalr, is_lui, is_aui;
  logic        known, use1, use2, wrd, bad_idx;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic signed [31:0] imm32;
  logic        hazard, accept, wb_we;

  function automatic logic idx_ok(logic [4:0] i);
    return 32'(i) < NREG;
  endfunction

  always_comb begin
    nop_s     = '0;
    nop_s.alu = ALU_NOP;
  end

  assign opc     = instr[6:0];
  assign is_r    = opc == 7'b0110011;
  assign is_i    = opc == 7'b0010011;
  assign is_ld   = opc == 7'b0000011;
  assign is_st   = opc == 7'b0100011;
  assign is_br   = opc == 7'b1100011;
  assign is_jalr = opc == 7'b1100111;
  assign is_jal  = opc == 7'b1101111;
  assign is_lui  = opc == 7'b0110111;
  assign is_aui  = opc == 7'b0010111;

  assign known = is_r | is_i | is_ld | is_st | is_br |
                 is_jal | is_jalr | is_lui | is_aui;
  assign use1  = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign use2  = is_r | is_st | is_br;
  assign wrd   = is_r | is_i | is_ld | is_jalr |
                 is_lui | is_aui | is_jal;

  // Unused fields read as x0 so they never match a hazard or bypass.
  assign rs1_i = use1 ? instr[19:15] : 5'd0;
  assign rs2_i = use2 ? instr[24:20] : 5'd0;
  assign rd_i  = wrd  ? instr[11:7]  : 5'd0;

  assign bad_idx = !idx_ok(rs1_i) || !idx_ok(rs2_i) ||
                   !idx_ok(rd_i);

  assign wb_we = wb_en && wb_idx != 5'd0 && idx_ok(wb_idx);

  assign hazard = slot_q.v && slot_q.mrd && slot_q.rd != 5'd0 &&
                  ((rs1_i != 5'd0 && rs1_i == slot_q.rd) ||
                   (rs2_i != 5'd0 && rs2_i == slot_q.rd));

  assign in_ready = !rst && (!slot_q.v || out_ready) &&
                    !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      is_i | is_ld | is_jalr:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      is_st:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      is_br:
        imm32 = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
      is_lui | is_aui:
        imm32 = {instr[31:12], 12'h000};
      is_jal:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  always_comb begin
    dec_s     = nop_s;
    dec_s.v   = 1'b1;
    dec_s.f3  = instr[14:12];
    dec_s.rs1 = rs1_i;
    dec_s.rs2 = rs2_i;
    dec_s.rd  = rd_i;
    dec_s.imm = XLEN'(imm32);
    dec_s.pc  = pc;
    dec_s.pc4 = pc4;
    dec_s.op1 = is_br | is_aui | is_jal;
    dec_s.op2 = is_r;
    dec_s.rds = is_jal | is_jalr;
    dec_s.mrd = is_ld;
    dec_s.mwr = is_st;
    unique case (1'b1)
      is_r:
        dec_s.alu = {instr[30], instr[14:12]};
      is_i:
        dec_s.alu = (instr[14:12] == 3'b101) ?
                    {instr[30], instr[14:12]} :
                    {1'b0, instr[14:12]};
      is_ld | is_st | is_br | is_jal |
      is_jalr | is_lui | is_aui:
        dec_s.alu = ALU_ADD;
      default:
        dec_s.alu = ALU_NOP;
    endcase
    unique case (1'b1)
      is_br:           dec_s.br = BR_COND;
      is_jal | is_jalr: dec_s.br = BR_UNC;
      default:         dec_s.br = BR_NO;
    endcase
    dec_s.d1 = '0;
    dec_s.d2 = '0;
    if (rs1_i != 5'd0 && idx_ok(rs1_i))
      dec_s.d1 = regs_q[rs1_i[IW-1:0]];
    if (rs2_i != 5'd0 && idx_ok(rs2_i))
      dec_s.d2 = regs_q[rs2_i[IW-1:0]];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_idx == rs1_i)
      dec_s.d1 = wb_data;
    if (wb_we && wb_idx == rs2_i)
      dec_s.d2 = wb_data;
`endif
    // Traps travel down as a bubble that only carries the flag.
    if (!known || bad_idx) begin
      dec_s.alu = ALU_NOP;
      dec_s.br  = BR_NO;
      dec_s.op1 = 1'b0;
      dec_s.op2 = 1'b0;
      dec_s.rds = 1'b0;
      dec_s.mrd = 1'b0;
      dec_s.mwr = 1'b0;
      dec_s.rd  = 5'd0;
      dec_s.ill = 1'b1;
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (flush)
      slot_d = nop_s;
    else if (accept)
      slot_d = dec_s;
    else if (out_ready)
      slot_d.v = 1'b0;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we)
      regs_d[wb_idx[IW-1:0]] = wb_data;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && in_valid && out_ready && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= nop_s;
      cnt_q  <= '0;
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      regs_q <= regs_d;
    end
  end

  assign out_valid = slot_q.v;
  assign alu_op    = slot_q.alu;
  assign br_op     = slot_q.br;
  assign funct3    = slot_q.f3;
  assign op1_ctrl  = slot_q.op1;
  assign op2_ctrl  = slot_q.op2;
  assign rd_src    = slot_q.rds;
  assign mem_rd    = slot_q.mrd;
  assign mem_wr    = slot_q.mwr;
  assign illegal   = slot_q.ill;
  assign rs1_idx   = slot_q.rs1;
  assign rs2_idx   = slot_q.rs2;
  assign rd_idx    = slot_q.rd;
  assign imm       = slot_q.imm;
  assign rs1_data  = slot_q.d1;
  assign rs2_data  = slot_q.d2;
  assign pc_o      = slot_q.pc;
  assign pc4_o     = slot_q.pc4;
  assign stall_cnt = cnt_q;

endmodule

// File: doc/stage_id_hs.md
STAGE_ID_HS -- requirements
Module: stage_id_hs

Interface
REQ-001 Parameter XLEN, 32, datapath and register width.
REQ-002 Parameter NREG, 32, register file entries; legal values are 16 (RV32E) or 32.
REQ-003 Parameter CNT_W, 16, width of the hazard-stall counter.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 instr, pc, pc4  in  32 / XLEN / XLEN  instruction and its PC and PC+4.
REQ-008 flush  in  1  kill the instruction in the slot and block acceptance this cycle.
REQ-009 wb_en, wb_idx, wb_data  in  1 / 5 / XLEN  register write-back port.
REQ-010 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-011 alu_op, br_op, funct3  out  4 / 2 / 3  decoded controls, using the shared definitions-header encodings.
REQ-012 op1_ctrl, op2_ctrl, rd_src, mem_rd, mem_wr, illegal  out  1 each  operand-source, memory and trap controls.
REQ-013 rs1_idx, rs2_idx, rd_idx  out  5 each; imm, rs1_data, rs2_data, pc_o, pc4_o  out  XLEN each.
REQ-014 stall_cnt  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-015 The block SHALL hold a single output slot; an instruction is accepted in a cycle where in_valid && in_ready.
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush, combinationally.
REQ-017 An instruction accepted at edge N SHALL present its decoded fields with out_valid=1 after edge N (latency 1).
REQ-018 While out_valid && !out_ready, every output except stall_cnt SHALL hold stable.
REQ-019 When the slot drains (out_ready=1) and no instruction is accepted, out_valid SHALL fall to 0 on that edge.
REQ-020 hazard SHALL be 1 when out_valid && mem_rd && rd_idx!=0 && the incoming instruction uses rs1 or rs2 (per its opcode) with a matching index.
REQ-021 Each edge where hazard && in_valid && out_ready SHALL insert one bubble and increment stall_cnt, saturating at all-ones.
REQ-022 flush SHALL take priority over acceptance: on the next edge out_valid=0, mem_rd=0, mem_wr=0, rd_idx=0, alu_op=NOP, br_op=NOBRA.
REQ-023 The register file SHALL hold NREG x XLEN entries; x0 reads 0; writes with wb_en=0, wb_idx=0 or wb_idx>=NREG SHALL be ignored.
REQ-024 Write-back SHALL proceed during flush, hazard and backpressure.
REQ-025 rs1_data/rs2_data SHALL be captured from the register file at acceptance.
REQ-026 For LUI, rs1 SHALL be forced to 0; for store and branch, rd_idx SHALL be 0.
REQ-027 Immediate formats: I for OP-IMM/LOAD/JALR, S, B, U for LUI/AUIPC, and J; otherwise 0.
REQ-028 alu_op SHALL be {funct7[5],funct3} for R-type and I-type shifts-right, {0,funct3} for other I-type, and ADD for load/store/branch/jump/LUI/AUIPC.
REQ-029 br_op SHALL be BrCond for branch, BrUcond for JAL/JALR, and NOBRA otherwise; rd_src SHALL be RdFromPC4 for JAL/JALR.
REQ-030 op1_ctrl SHALL be OP1FromPC for branch/AUIPC/JAL; op2_ctrl SHALL be OP2FromRS2 only for R-type.
REQ-031 An unknown opcode, or any used register index >=NREG, SHALL set illegal=1 with out_valid=1 and NOP controls (mem_rd=mem_wr=0, rd_idx=0).

Reset
REQ-032 While rst=1: out_valid=0, in_ready=0, all controls in their NOP/zero values, indices/imm/data/pc outputs=0, stall_cnt=0, all register file entries=0.
REQ-033 Reset asserted mid-stall or mid-backpressure SHALL discard the slot contents with no output on the following cycle.

Configuration
REQ-034 Macro ID_WB_BYPASS_EN defined: when wb_en && wb_idx matches an accepted rs index (nonzero), that operand SHALL capture wb_data (write-first).
REQ-035 Macro ID_WB_BYPASS_EN undefined: the operand SHALL capture the pre-write register value; forwarding is the executor's job.

Verification
REQ-036 Reset, then accept `addi x1,x0,5` (0x00500093) -> next cycle out_valid=1, imm=5, alu_op=ADD, rd_idx=1, op2_ctrl=IMM.
REQ-037 Slot holds `lw x2,0(x1)`; present `add x3,x2,x2` -> in_ready=0, one bubble inserted, stall_cnt=1, add accepted one cycle later.
REQ-038 wb_en=1, wb_idx=4, wb_data=0xDEADBEEF in the same cycle `add x5,x4,x0` is accepted -> rs1_data=0xDEADBEEF with the macro, old value without.
REQ-039 out_ready=0 for 3 cycles with the slot full -> outputs frozen, in_ready=0; flush asserted -> out_valid=0, mem_wr=0 on the next edge.
REQ-040 NREG=16 with `add x17,x1,x2` -> illegal=1, rd_idx=0; a write to wb_idx=20 leaves all registers unchanged.
